// File: rtl/fpu_issue_sched.sv
// rtl/fpu_issue_sched.sv - round-robin FPU issue scheduler with shared register-file write port
// Optional watchdog on the in-flight operation: define FPU_SCHED_TIMEOUT_EN.
module fpu_issue_sched #(
  parameter int NREQ           = 4,
  parameter int AW             = 5,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_fs,
  input  logic [NREQ*AW-1:0] req_ft,
  input  logic [NREQ*AW-1:0] req_fd,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic [AW-1:0]      done_dst,
  input  logic               m_req,
  input  logic [AW-1:0]      m_addr_i,
  input  logic [DW-1:0]      m_data_i,
  output logic               m_ack,
  output logic               start,
  output logic [AW-1:0]      fs_addr,
  output logic [AW-1:0]      ft_addr,
  output logic [AW-1:0]      fd_addr,
  output logic [AW-1:0]      m_addr,
  output logic [DW-1:0]      m_data,
  output logic               m_write,
  input  logic               working,
  output logic               busy,
  output logic               timeout_err
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_HI,
    S_BUSY,
    S_RETIRE
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, own_q, own_d;
  logic [AW-1:0] fs_q, fs_d, ft_q, ft_d, fd_q, fd_d;

  logic          win_vld;
  logic [IW-1:0] win;
  logic [AW-1:0] win_fs, win_ft, win_fd;

  // Pass 0 scans requesters at or above rr_q, pass 1 wraps around to the ones below it.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    win_fs  = '0;
    win_ft  = '0;
    win_fd  = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!win_vld && req[i] && ((p == 0) == (i >= int'(rr_q)))) begin
          win_vld = 1'b1;
          win     = IW'(i);
          win_fs  = req_fs[i*AW +: AW];
          win_ft  = req_ft[i*AW +: AW];
          win_fd  = req_fd[i*AW +: AW];
        end
      end
    end
  end

`ifdef FPU_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    own_d    = own_q;
    fs_d     = fs_q;
    ft_d     = ft_q;
    fd_d     = fd_q;
    gnt      = '0;
    done     = '0;
    done_dst = '0;
    m_ack    = 1'b0;
    m_write  = 1'b0;
    m_addr   = '0;
    m_data   = '0;
    start    = 1'b0;
    fs_addr  = '0;
    ft_addr  = '0;
    fd_addr  = '0;
    busy     = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        // Gated by rst so that grant/ack stay quiet while reset is held.
        if (rst) begin
          if (m_req) begin
            m_write = 1'b1;
            m_ack   = 1'b1;
            m_addr  = m_addr_i;
            m_data  = m_data_i;
          end else if (win_vld) begin
            gnt[win] = 1'b1;
            own_d    = win;
            fs_d     = win_fs;
            ft_d     = win_ft;
            fd_d     = win_fd;
            rr_d     = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
            state_d  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        start   = 1'b1;
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: if (working) state_d = S_BUSY;
      S_BUSY:    if (!working) state_d = S_RETIRE;
      S_RETIRE: begin
        done[own_q] = 1'b1;
        done_dst    = fd_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE) begin
      fs_addr = fs_q;
      ft_addr = ft_q;
      fd_addr = fd_q;
    end

`ifdef FPU_SCHED_TIMEOUT_EN
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == S_ISSUE) begin
      cnt_d = '0;
    end else if (state_q == S_WAIT_HI || state_q == S_BUSY) begin
      if (cnt_q == CW'(TIMEOUT_CYCLES) && state_d != S_RETIRE) begin
        state_d = S_RETIRE;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    timeout_err = err_q;
`else
    timeout_err = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      own_q   <= '0;
      fs_q    <= '0;
      ft_q    <= '0;
      fd_q    <= '0;
`ifdef FPU_SCHED_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      own_q   <= own_d;
      fs_q    <= fs_d;
      ft_q    <= ft_d;
      fd_q    <= fd_d;
`ifdef FPU_SCHED_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_fpu_issue_sched.sv
// tb/tb_fpu_issue_sched.sv - directed self-checking bench for fpu_issue_sched
// Watchdog scenario depends on FPU_SCHED_TIMEOUT_EN.
module tb_fpu_issue_sched;

  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_fs, req_ft, req_fd;
  logic [NREQ-1:0]    gnt, done;
  logic [AW-1:0]      done_dst;
  logic               m_req;
  logic [AW-1:0]      m_addr_i;
  logic [DW-1:0]      m_data_i;
  logic               m_ack, start;
  logic [AW-1:0]      fs_addr, ft_addr, fd_addr, m_addr;
  logic [DW-1:0]      m_data;
  logic               m_write, working, busy, timeout_err;

  int n_chk  = 0;
  int n_fail = 0;

  fpu_issue_sched #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_fs(req_fs), .req_ft(req_ft), .req_fd(req_fd),
    .gnt(gnt), .done(done), .done_dst(done_dst), .m_req(m_req), .m_addr_i(m_addr_i),
    .m_data_i(m_data_i), .m_ack(m_ack), .start(start), .fs_addr(fs_addr), .ft_addr(ft_addr),
    .fd_addr(fd_addr), .m_addr(m_addr), .m_data(m_data), .m_write(m_write),
    .working(working), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int i, input int fs, input int ft, input int fd);
    req_fs[i*AW +: AW] = fs[AW-1:0];
    req_ft[i*AW +: AW] = ft[AW-1:0];
    req_fd[i*AW +: AW] = fd[AW-1:0];
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 4'b1111; m_req = 1'b1; m_addr_i = 5'd3; m_data_i = 32'h1234_5678;
    #1;
    n_chk++;
    if ({gnt, done, done_dst, m_ack, start, fs_addr, ft_addr, fd_addr, m_addr, m_data,
         m_write, busy, timeout_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: gnt=%b done=%b m_ack=%b m_write=%b busy=%b err=%b, required all 0",
               gnt, done, m_ack, m_write, busy, timeout_err);
    end
    req = '0; m_req = 1'b0;
    step();
    rst = 1'b1;
    step();
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    for (int i = 0; i < NREQ; i++) set_cmd(i, i, i + 20, 10 + i);
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      eg = 4'b0001 << (n % 4);
      #1;
      n_chk++;
      if (gnt !== eg) begin n_fail++; $display("FAIL rr_gnt%0d: got %b required %b", n, gnt, eg); end
      step();
      n_chk++;
      if (start !== 1'b1 || fd_addr !== AW'(10 + n % 4)) begin
        n_fail++; $display("FAIL rr_start%0d: start=%b fd=%0d required 1/%0d", n, start, fd_addr, 10 + n % 4);
      end
      step(); working = 1'b1;
      step(); working = 1'b0;
      step();
      if (n == 4) req = '0;
      #1;
      n_chk++;
      if (done !== eg || done_dst !== AW'(10 + n % 4) || gnt !== 4'b0000) begin
        n_fail++;
        $display("FAIL rr_done%0d: done=%b dst=%0d gnt=%b required %b/%0d/0000", n, done, done_dst, gnt, eg, 10 + n % 4);
      end
      step();
    end
  endtask

  task automatic test_single();
    set_cmd(1, 3, 4, 7);
    req = 4'b0010;
    #1;
    n_chk++;
    if (gnt !== 4'b0010) begin n_fail++; $display("FAIL single_gnt: got %b required 0010", gnt); end
    step(); req = '0;
    #1;
    n_chk++;
    if (start !== 1'b1 || fs_addr !== 5'd3 || ft_addr !== 5'd4 || fd_addr !== 5'd7 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_start: start=%b fs=%0d ft=%0d fd=%0d busy=%b required 1/3/4/7/1", start, fs_addr, ft_addr, fd_addr, busy);
    end
    step(); working = 1'b1;
    #1;
    n_chk++;
    if (start !== 1'b0 || fd_addr !== 5'd7) begin
      n_fail++; $display("FAIL single_wait: start=%b fd=%0d required 0/7", start, fd_addr);
    end
    repeat (4) step();
    working = 1'b0;
    #1;
    n_chk++;
    if (done !== 4'b0000) begin n_fail++; $display("FAIL single_early_done: got %b required 0000", done); end
    step();
    n_chk++;
    if (done !== 4'b0010 || done_dst !== 5'd7) begin
      n_fail++; $display("FAIL single_done: done=%b dst=%0d required 0010/7", done, done_dst);
    end
    step();
    n_chk++;
    if (busy !== 1'b0 || done !== 4'b0000 || fd_addr !== 5'd0) begin
      n_fail++; $display("FAIL single_idle: busy=%b done=%b fd=%0d required 0/0000/0", busy, done, fd_addr);
    end
  endtask

  task automatic test_reset_mid_busy();
    set_cmd(2, 1, 2, 9);
    req = 4'b0100;
    step(); req = '0;
    step(); working = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_chk++;
    if (busy !== 1'b0 || start !== 1'b0 || fd_addr !== 5'd0 || done !== 4'b0000) begin
      n_fail++; $display("FAIL midreset_outputs: busy=%b start=%b fd=%0d done=%b required 0", busy, start, fd_addr, done);
    end
    step();
    rst = 1'b1; working = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_chk++;
      if (done !== 4'b0000 || busy !== 1'b0) begin
        n_fail++; $display("FAIL midreset_quiet%0d: done=%b busy=%b required 0000/0", k, done, busy);
      end
    end
  endtask

  task automatic test_collision();
    set_cmd(0, 5, 6, 12);
    req = 4'b0001; m_req = 1'b1; m_addr_i = 5'd9; m_data_i = 32'hDEAD_BEEF;
    #1;
    n_chk++;
    if (m_ack !== 1'b1 || m_write !== 1'b1 || m_addr !== 5'd9 || m_data !== 32'hDEAD_BEEF || gnt !== 4'b0000) begin
      n_fail++; $display("FAIL coll_mem: ack=%b wr=%b addr=%0d data=%h gnt=%b required 1/1/9/deadbeef/0000", m_ack, m_write, m_addr, m_data, gnt);
    end
    step(); m_req = 1'b0;
    #1;
    n_chk++;
    if (gnt !== 4'b0001 || m_ack !== 1'b0) begin
      n_fail++; $display("FAIL coll_gnt: gnt=%b ack=%b required 0001/0", gnt, m_ack);
    end
    step(); req = '0;
    step(); working = 1'b1;
    step(); m_req = 1'b1;
    #1;
    n_chk++;
    if (m_ack !== 1'b0 || m_write !== 1'b0) begin
      n_fail++; $display("FAIL coll_busy_mem: ack=%b wr=%b required 0/0", m_ack, m_write);
    end
    step(); working = 1'b0;
    step();
    n_chk++;
    if (done !== 4'b0001 || done_dst !== 5'd12 || m_ack !== 1'b0 || m_write !== 1'b0) begin
      n_fail++; $display("FAIL coll_retire: done=%b dst=%0d ack=%b wr=%b required 0001/12/0/0", done, done_dst, m_ack, m_write);
    end
    step();
    n_chk++;
    if (m_ack !== 1'b1 || m_write !== 1'b1) begin
      n_fail++; $display("FAIL coll_after: ack=%b wr=%b required 1/1", m_ack, m_write);
    end
    m_req = 1'b0;
    step();
  endtask

  task automatic test_watchdog();
    set_cmd(3, 2, 3, 17);
    req = 4'b1000;
    step(); req = '0;
    step();
`ifdef FPU_SCHED_TIMEOUT_EN
    repeat (8) step();
    n_chk++;
    if (done !== 4'b0000 || busy !== 1'b1) begin
      n_fail++; $display("FAIL wd_early: done=%b busy=%b required 0000/1", done, busy);
    end
    step();
    n_chk++;
    if (done !== 4'b1000 || done_dst !== 5'd17 || timeout_err !== 1'b1) begin
      n_fail++; $display("FAIL wd_done: done=%b dst=%0d err=%b required 1000/17/1", done, done_dst, timeout_err);
    end
    repeat (3) step();
    n_chk++;
    if (busy !== 1'b0 || timeout_err !== 1'b1) begin
      n_fail++; $display("FAIL wd_sticky: busy=%b err=%b required 0/1", busy, timeout_err);
    end
`else
    repeat (20) step();
    n_chk++;
    if (busy !== 1'b1 || done !== 4'b0000 || timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL wd_stuck: busy=%b done=%b err=%b required 1/0000/0", busy, done, timeout_err);
    end
    working = 1'b1;
    step(); working = 1'b0;
    step();
    n_chk++;
    if (done !== 4'b1000 || done_dst !== 5'd17) begin
      n_fail++; $display("FAIL wd_recover: done=%b dst=%0d required 1000/17", done, done_dst);
    end
    step();
`endif
  endtask

  initial begin
    rst = 1'b0; req = '0; req_fs = '0; req_ft = '0; req_fd = '0;
    m_req = 1'b0; m_addr_i = '0; m_data_i = '0; working = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_round_robin();
    test_single();
    test_reset_mid_busy();
    test_collision();
    test_watchdog();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_issue_sched.md
# fpu_issue_sched

Issue scheduler that shares the single floating-point add unit and its register-file write port among `NREQ` requesters and one memory-write requester. It sits directly in front of the FPU block. It arbitrates round-robin among operation requests, drives the FPU `start`/address handshake, and tracks the in-flight operation until `working` falls. It forwards memory register writes only when no FPU result can collide with them on the shared write port.

## Interface
Parameters:
- `NREQ`, 4: number of operation requesters (2..8).
- `AW`, 5: register address width (`RegAddr`).
- `DW`, 32: register data width (`Register`).
- `TIMEOUT_CYCLES`, 64: watchdog limit; used only with `FPU_SCHED_TIMEOUT_EN`.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req` in NREQ: per-requester operation request, level, held until granted.
- `req_fs` in NREQ*AW: packed source-A addresses; requester i at `[i*AW +: AW]`.
- `req_ft` in NREQ*AW: packed source-B addresses.
- `req_fd` in NREQ*AW: packed destination addresses.
- `gnt` out NREQ: one-hot, 1-cycle pulse; command captured this cycle.
- `done` out NREQ: one-hot, 1-cycle pulse when that requester's operation retires.
- `done_dst` out AW: destination of the retiring operation; valid with `done`.
- `m_req` in 1: memory register-write request, level, held until acked.
- `m_addr_i` in AW: memory write address.
- `m_data_i` in DW: memory write data.
- `m_ack` out 1: 1-cycle pulse; write issued this cycle.
- `start` out 1: FPU start.
- `fs_addr`, `ft_addr`, `fd_addr` out AW: FPU operand and destination addresses.
- `m_addr` out AW, `m_data` out DW, `m_write` out 1: FPU register-file memory write port.
- `working` in 1: FPU busy flag.
- `busy` out 1: high in every state except IDLE.
- `timeout_err` out 1: sticky watchdog error; constant 0 without the macro.

## Operation
The FSM has five states: IDLE, ISSUE, WAIT_HI, BUSY and RETIRE.

- **IDLE**
  - If `m_req` is high, the memory write wins. Drive `m_write=1`, `m_addr`/`m_data` from the inputs, and pulse `m_ack`. Stay in IDLE.
  - Otherwise, if any `req` is high, select the winner round-robin, starting at `rr_ptr`. Latch its fs/ft/fd and owner index, pulse `gnt[winner]`, set `rr_ptr = winner+1` (mod NREQ), and go to ISSUE.
- **ISSUE**: drive `start=1` with the latched addresses for exactly one cycle, then go to WAIT_HI.
- **WAIT_HI**: hold the addresses and `start=0`. When `working=1`, go to BUSY.
- **BUSY**: when `working=0`, go to RETIRE.
- **RETIRE**: pulse `done[owner]` and drive `done_dst=latched fd`. Return to IDLE. Memory writes are not accepted in this cycle.
- `fs_addr`/`ft_addr`/`fd_addr` hold the latched command from ISSUE through RETIRE, and are 0 in IDLE.
- `m_write` is asserted only in IDLE. Memory writes are therefore never concurrent with FPU completion.
- A requester whose `req` drops before it is granted is simply skipped. Requesters must not change their address fields while `req` is high.

## Timing
- **Reset (`rst`=0)**
  - FSM goes to IDLE and `rr_ptr` to 0.
  - All outputs are 0: `gnt`, `done`, `done_dst`, `m_ack`, `start`, the address outputs, `m_data`, `m_write`, `busy` and `timeout_err`.
  - Reset mid-operation abandons the latched command; no `done` is generated for it.
- **Grant latency**: `gnt` is combinational from state and `req` in the IDLE cycle (cycle T). `start` is asserted at T+1. `working` is expected high from T+2.
- **Retire**: `done` is asserted one cycle after the first sampled `working=0` in BUSY.
- **Throughput**: back-to-back operations are separated by one IDLE cycle after RETIRE.
- **Simultaneous `m_req` and `req` in IDLE**: the memory write goes first, and the operation is granted on the next IDLE cycle.
- **Continuous `m_req`**: starvation of operations is permitted and is the caller's responsibility.
- **`working` stuck at 0 in WAIT_HI**: the FSM waits indefinitely, unless the timeout feature is compiled in.

## Configuration
Macro: `FPU_SCHED_TIMEOUT_EN`.
- **Defined**
  - A counter clears on entry to WAIT_HI and increments every cycle in WAIT_HI and BUSY.
  - When it reaches `TIMEOUT_CYCLES`, the FSM goes to RETIRE. `done[owner]` still pulses, and `timeout_err` is set and stays set until reset.
- **Undefined**: no counter is built and `timeout_err` is tied to 0.

## Test plan
- **Reset**: assert `rst`=0 mid-BUSY -> all outputs 0 immediately; after release, `busy`=0 and no `done` pulse.
- **Single operation**: `req`=4'b0010 with fs=3/ft=4/fd=7 at T; `working` high T+2..T+6 -> `gnt`=0010 at T, `start` at T+1 with `fd_addr`=7, `done`=0010 and `done_dst`=7 at T+8.
- **Round robin**: all four `req` held continuously -> grant order 0,1,2,3,0, each grant issued only after the previous `done`.
- **Collision**: `m_req` and `req[0]` both high in IDLE -> `m_ack` and `m_write` in that cycle, `gnt[0]` next cycle; `m_req` raised during BUSY -> `m_ack` only after RETIRE.
- **Watchdog** (macro defined, `TIMEOUT_CYCLES`=8): `working` never rises -> `done` pulses 9 cycles after WAIT_HI entry, and `timeout_err`=1 stays set.
